seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Moore serial-pattern detector.
- Successor to the fixed 3-bit "101" non-overlapping detector. Pattern length is generic, the pattern is loadable at run time, and overlapping or non-overlapping mode is selected per cycle. An optional saturating match counter is available.
- Sits on a 1-bit serial data path and flags each complete pattern occurrence with a one-cycle Moore pulse.

Parameters:
- SEQ_LEN, 3, pattern length in bits; must be at least 2.
- SEQ_RST, 3'b101, pattern loaded at reset; width SEQ_LEN; MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable; x is consumed only when en=1.
- x  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- load  input  1  synchronous load of pattern_in.
- pattern_in  input  SEQ_LEN  new pattern; MSB is the first bit received.
- clr_cnt  input  1  synchronous clear of match_cnt.
- y  output  1  match pulse (registered, Moore).
- match_cnt  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): hist=0, fill=0, y=0, pattern=SEQ_RST, match_cnt=0. These values hold while rst_n=0. The first sample is taken on the first rising edge after release.
- State: hist (SEQ_LEN-bit shift register), fill (0..SEQ_LEN, count of valid bits), pattern register.
- Each edge with en=1 and load=0:
  - hist_n = {hist[SEQ_LEN-2:0], x}
  - fill_n = min(fill+1, SEQ_LEN)
  - hit = (fill_n==SEQ_LEN) && (hist_n==pattern)
  - y <= hit; hist <= hist_n.
  - If hit and overlap=0: fill <= 0, so the bits of the matched pattern are consumed. Otherwise fill <= fill_n.
- Latency: y is high for exactly the one cycle following the edge that samples the final pattern bit. With continuous input this is the same timing as the fixed Moore detector.
- Edge with en=0 and load=0: hist and fill hold; y <= 0. Gaps in en do not break a partial match.
- Edge with load=1, which has priority over en:
  - pattern <= pattern_in; fill <= 0; y <= 0.
  - The x sample on that edge is discarded. hist is not required to be cleared, because fill gates matching.
- overlap is sampled on each edge. A change applies only to the hit decision on that edge; earlier history is not re-evaluated.
- Non-overlap boundary: after a hit, a new match needs SEQ_LEN fresh bits.
- Overlap boundary: a hit can occur on every edge, e.g. pattern 111 with x held at 1.
- Once fill saturates at SEQ_LEN it stays there, with no wrap-around.
- Reset mid-pattern aborts detection immediately: y drops asynchronously and any partial match is lost.
- Widths: all comparisons are exactly SEQ_LEN bits wide, with no sign extension.

Optional Feature:
- Macro: SEQDET_MATCH_CNT_EN.
- Defined:
  - match_cnt increments on every edge where hit=1 and saturates at 2^CNT_W-1.
  - clr_cnt=1 sets match_cnt to 0 and has priority over a simultaneous hit.
  - load does not affect match_cnt.
- Undefined: match_cnt is tied to 0, clr_cnt is ignored, and no counter flops are generated. Port list is unchanged.

Test Plan:
- Defaults, overlap=0, en=1, stream 0,1,0,1,0,1,1,1 after reset release:
  - y high only in the cycle after the 4th sampled bit.
  - No second pulse after the 6th bit (non-overlap).
  - match_cnt=1.
- Same stream with overlap=1: y pulses after bit 4 and after bit 6; match_cnt=2.
- Stream 1,0 then en=0 for 3 cycles then en=1 with x=1: y=0 during the gap; y=1 the cycle after the x=1 sample.
- load with pattern_in=3'b110, then stream 1,1,0,1,1,0 with overlap=0: y pulses after the 3rd and 6th samples; the x sampled on the load edge does not count.
- Reset mid-pattern: bits 1,0, then rst_n pulsed low between edges, then 1:
  - y=0 throughout.
  - Pattern returns to 101.
  - Then 1,0,1 gives one pulse.
- With CNT_W=2, overlap=1, pattern 111, x=1 held for 6 cycles:
  - y high for 4 consecutive cycles; match_cnt saturates at 3.
  - clr_cnt=1 on a hit edge gives match_cnt=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with a run-time loadable pattern and per-cycle
// overlap select. Defining SEQDET_MATCH_CNT_EN builds the saturating match counter.
module seq_detector_param #(
  parameter int unsigned        SEQ_LEN = 3,
  parameter logic [SEQ_LEN-1:0] SEQ_RST = 3'b101,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               x,
  input  logic               overlap,
  input  logic               load,
  input  logic [SEQ_LEN-1:0] pattern_in,
  input  logic               clr_cnt,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int unsigned FillW = $clog2(SEQ_LEN + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(SEQ_LEN);

  logic [SEQ_LEN-1:0] hist_q, hist_d, hist_n;
  logic [SEQ_LEN-1:0] pattern_q, pattern_d;
  logic [FillW-1:0]   fill_q, fill_d, fill_n;
  logic               y_q, y_d;
  logic               hit;

  assign hist_n = {hist_q[SEQ_LEN-2:0], x};
  assign fill_n = (fill_q == FillMax) ? FillMax : fill_q + FillW'(1);
  // fill gates matching, so stale history after a load or hit can never fire
  assign hit    = en && !load && (fill_n == FillMax) && (hist_n == pattern_q);

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    y_d       = 1'b0;
    if (load) begin
      pattern_d = pattern_in;
      fill_d    = '0;
    end else if (en) begin
      hist_d = hist_n;
      y_d    = hit;
      fill_d = (hit && !overlap) ? '0 : fill_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= SEQ_RST;
      y_q       <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      y_q       <= y_d;
    end
  end

  assign y = y_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed vectors push expected y/match_cnt,
// a monitor pops and compares one entry after each rising edge.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       overlap = 1'b0;
  logic       load = 1'b0;
  logic [2:0] pattern_in = 3'b000;
  logic       clr_cnt = 1'b0;
  logic       y;
  logic [1:0] match_cnt;

  int n_vec = 0;
  int n_err = 0;
  string tag = "init";

  typedef struct {
    string      name;
    logic       y;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  seq_detector_param #(
    .SEQ_LEN(3),
    .SEQ_RST(3'b101),
    .CNT_W  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .x         (x),
    .overlap   (overlap),
    .load      (load),
    .pattern_in(pattern_in),
    .clr_cnt   (clr_cnt),
    .y         (y),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] cnt_exp(input logic [1:0] c);
`ifdef SEQDET_MATCH_CNT_EN
    return c;
`else
    return 2'd0;
`endif
  endfunction

  task automatic check(input string name, input logic ay, input logic ey,
                       input logic [1:0] ac, input logic [1:0] ec);
    n_vec++;
    if (ay !== ey || ac !== ec) begin
      n_err++;
      $display("FAIL %s: y=%0b match_cnt=%0d, required y=%0b match_cnt=%0d",
               name, ay, ac, ey, ec);
    end
  endtask

  // Drive one vector ahead of the next rising edge and queue the response expected after it.
  task automatic step(input logic xi, input logic ei, input logic oi, input logic li,
                      input logic [2:0] pi, input logic ci, input logic ey, input logic [1:0] ec);
    exp_t e;
    @(negedge clk);
    x = xi; en = ei; overlap = oi; load = li; pattern_in = pi; clr_cnt = ci;
    e.name = $sformatf("%s#%0d", tag, n_vec + sb_q.size());
    e.y    = ey;
    e.cnt  = cnt_exp(ec);
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    x = 1'b0; en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, y, e.y, match_cnt, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    tag = "reset";
    check("reset", y, 1'b0, match_cnt, 2'd0);
    rst_n = 1'b1;

    // 101 non-overlapping: one pulse after bit 4, none after bit 6
    tag = "nonovl";
    step(0, 1, 0, 0, 3'b000, 0, 0, 0);
    step(1, 1, 0, 0, 3'b000, 0, 0, 0);
    step(0, 1, 0, 0, 3'b000, 0, 0, 0);
    step(1, 1, 0, 0, 3'b000, 0, 1, 1);
    step(0, 1, 0, 0, 3'b000, 0, 0, 1);
    step(1, 1, 0, 0, 3'b000, 0, 0, 1);
    step(1, 1, 0, 0, 3'b000, 0, 0, 1);
    step(1, 1, 0, 0, 3'b000, 0, 0, 1);
    step(0, 0, 0, 0, 3'b000, 1, 0, 0);

    // Same stream overlapping, after a reload to restart fill
    tag = "ovl";
    step(1, 1, 1, 1, 3'b101, 0, 0, 0);
    step(0, 1, 1, 0, 3'b000, 0, 0, 0);
    step(1, 1, 1, 0, 3'b000, 0, 0, 0);
    step(0, 1, 1, 0, 3'b000, 0, 0, 0);
    step(1, 1, 1, 0, 3'b000, 0, 1, 1);
    step(0, 1, 1, 0, 3'b000, 0, 0, 1);
    step(1, 1, 1, 0, 3'b000, 0, 1, 2);
    step(1, 1, 1, 0, 3'b000, 0, 0, 2);
    step(1, 1, 1, 0, 3'b000, 0, 0, 2);
    step(0, 0, 1, 0, 3'b000, 1, 0, 0);

    // en gap keeps the partial match; x during the gap is ignored
    tag = "gap";
    step(0, 1, 0, 1, 3'b101, 0, 0, 0);
    step(1, 1, 0, 0, 3'b000, 0, 0, 0);
    step(0, 1, 0, 0, 3'b000, 0, 0, 0);
    step(1, 0, 0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    step(1, 0, 0, 0, 3'b000, 0, 0, 0);
    step(1, 1, 0, 0, 3'b000, 0, 1, 1);
    step(1, 0, 0, 0, 3'b000, 0, 0, 1);

    // Load 110; x on the load edge is discarded; counter untouched by load
    tag = "load110";
    step(1, 1, 0, 1, 3'b110, 0, 0, 1);
    step(1, 1, 0, 0, 3'b000, 0, 0, 1);
    step(1, 1, 0, 0, 3'b000, 0, 0, 1);
    step(0, 1, 0, 0, 3'b000, 0, 1, 2);
    step(1, 1, 0, 0, 3'b000, 0, 0, 2);
    step(1, 1, 0, 0, 3'b000, 0, 0, 2);
    step(0, 1, 0, 0, 3'b000, 0, 1, 3);

    // Reset mid-pattern restores 101 and drops the partial match
    tag = "midrst";
    step(1, 1, 0, 0, 3'b000, 0, 0, 3);
    step(0, 1, 0, 0, 3'b000, 0, 0, 3);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("midrst_low", y, 1'b0, match_cnt, cnt_exp(2'd0));
    #1;
    rst_n = 1'b1;
    step(1, 1, 0, 0, 3'b000, 0, 0, 0);
    step(1, 1, 0, 0, 3'b000, 0, 0, 0);
    step(0, 1, 0, 0, 3'b000, 0, 0, 0);
    step(1, 1, 0, 0, 3'b000, 0, 1, 1);

    // y must fall asynchronously while the pulse is still high
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("async_drop", y, 1'b0, match_cnt, cnt_exp(2'd0));
    #1;
    rst_n = 1'b1;

    // 111 overlapping with x held high: hit every edge, counter saturates at 3
    tag = "sat";
    step(1, 1, 1, 1, 3'b111, 0, 0, 0);
    step(1, 1, 1, 0, 3'b000, 0, 0, 0);
    step(1, 1, 1, 0, 3'b000, 0, 0, 0);
    step(1, 1, 1, 0, 3'b000, 0, 1, 1);
    step(1, 1, 1, 0, 3'b000, 0, 1, 2);
    step(1, 1, 1, 0, 3'b000, 0, 1, 3);
    step(1, 1, 1, 0, 3'b000, 0, 1, 3);
    step(1, 1, 1, 0, 3'b000, 1, 1, 0);
    step(1, 1, 1, 0, 3'b000, 0, 1, 1);
    // Switching to non-overlap consumes the match: next hit needs 3 fresh bits
    step(1, 1, 0, 0, 3'b000, 0, 1, 2);
    step(1, 1, 0, 0, 3'b000, 0, 0, 2);
    step(1, 1, 0, 0, 3'b000, 0, 0, 2);
    step(1, 1, 0, 0, 3'b000, 0, 1, 3);
    step(1, 0, 0, 0, 3'b000, 0, 0, 3);

    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left in scoreboard, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
